cntrl_pipe_hz: RTL and testbench
================================

Name: cntrl_pipe_hz

Overview:
Parametrised control-signal pipeline for the 5-stage CPU. It carries the decoded control bundle through the ID/EX, EX/MEM and MEM/WB registers, split into EX, MEM and WB groups of configurable width. Unlike the fixed 3-register control chain, every stage tracks a valid bit and zero-gates its outputs when invalid. The hazard unit can stall ID/EX, flush ID/EX or EX, or freeze the whole pipe. A saturating bubble counter is provided for performance monitoring.

Parameters:
EX_W, 6, width of EX-stage control group (ALUSrc, ChooseImm, ChooseMovk, ChooseMovz, ALUOp...)
MEM_W, 4, width of MEM-stage control group (MemToReg, MemWrite, MemRead, xferByte)
WB_W, 2, width of WB-stage control group (RegWrite, spare)
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
hold_all  input  1  freeze: all registers and counter hold
stall_idex  input  1  hold ID/EX contents; inject bubble into EX/MEM
flush_idex  input  1  load bubble into ID/EX
flush_ex  input  1  kill instruction leaving EX; EX/MEM gets bubble
in_valid  input  1  decode-stage bundle valid
in_ex  input  EX_W  decoded EX controls
in_mem  input  MEM_W  decoded MEM controls
in_wb  input  WB_W  decoded WB controls
ex_valid  output  1  ID/EX valid
ex_ctrl  output  EX_W  EX controls, zero when ex_valid=0
mem_valid  output  1  EX/MEM valid
mem_ctrl  output  MEM_W  MEM controls, zero when mem_valid=0
wb_valid  output  1  MEM/WB valid
wb_ctrl  output  WB_W  WB controls, zero when wb_valid=0
bubble_count  output  CNT_W  saturating count of injected EX/MEM bubbles

Behaviour:
- Reset (reset=0, asynchronous): all valids, stored groups and bubble_count go to 0; all outputs read 0 while reset is low. First load happens on the first rising edge after reset returns to 1.
- Stored data is zeroed on any bubble load. Outputs are also AND-gated with their stage valid, so in_valid=0 with nonzero in_* never reaches an output.
- Latency with no hazards: in_* appears on ex_ctrl 1 cycle after sampling, on mem_ctrl after 2 cycles, and on wb_ctrl after 3 cycles.
- Priority per rising edge (highest first):
  1. hold_all=1: every register and the counter hold; all other controls are ignored.
  2. ID/EX update: flush_idex loads a bubble (valid=0, groups 0). Otherwise stall_idex holds the current contents. Otherwise ID/EX loads {in_valid, in_ex, in_mem, in_wb}. flush_idex overrides stall_idex.
  3. EX/MEM update: if flush_ex=1 or stall_idex=1, EX/MEM loads a bubble. Otherwise it loads {ex_valid, ID/EX mem group, ID/EX wb group}. flush_ex and flush_idex together kill both the EX instruction and the ID/EX entry.
  4. MEM/WB update: always loads {mem_valid, EX/MEM wb group}; no stall or flush applies.
- Bubble counter: increments by 1 on each edge where hold_all=0 and EX/MEM loads a bubble because of stall_idex or flush_ex. An already-invalid entry flowing through counts only if stall_idex or flush_ex caused the load. The counter saturates at 2^CNT_W-1 with no wrap and clears only on reset.
- A stall held for N cycles keeps ex_ctrl constant for N+1 cycles and injects N consecutive EX/MEM bubbles.
- Reset asserted mid-stall or mid-flush clears everything immediately. No hazard state persists after reset.

Test Plan:
- Flow: in_valid=1, in_ex=6'h2A, in_mem=4'h5, in_wb=2'b01 for 1 cycle, then in_valid=0 -> ex_ctrl=2A at edge+1, mem_ctrl=5 at +2, wb_ctrl=01 at +3; bubble_count stays 0.
- Invalid gating: in_valid=0, in_ex=6'h3F, in_mem=4'hF, in_wb=2'b11 -> all *_ctrl=0 and all *_valid=0 at every stage.
- Stall: load A (in_ex=6'h11), then stall_idex=1 for 2 cycles while presenting B (in_ex=6'h22) -> ex_ctrl=11 for 3 cycles; mem_valid=0 for 2 cycles; B enters EX only after the stall drops; bubble_count=2.
- Flush: flush_ex=1 while A (MemWrite bit set) is in EX -> mem_valid=0 and mem_ctrl=0 next cycle, wb_valid=0 the cycle after; bubble_count+1. flush_idex=1 together with stall_idex=1 -> ex_valid=0 (flush wins).
- Freeze and saturation: hold_all=1 for 3 cycles with stall_idex=1 -> all outputs and bubble_count unchanged. With CNT_W=2, 5 stall cycles -> bubble_count stops at 3.
- Async reset: drop reset between edges mid-stall with all stages valid -> all outputs 0 immediately; after reset=1, the next in_valid=1 bundle reaches ex_ctrl one edge later.

Source files
------------

// File: rtl/cntrl_pipe_hz.sv
// cntrl_pipe_hz: control-bundle pipeline (ID/EX, EX/MEM, MEM/WB) with
// per-stage valid bits, valid-gated outputs, hazard stall/flush/freeze
// controls and a saturating EX/MEM bubble counter.
module cntrl_pipe_hz #(
   parameter int unsigned EX_W  = 6,
   parameter int unsigned MEM_W = 4,
   parameter int unsigned WB_W  = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold_all,
   input  logic             stall_idex,
   input  logic             flush_idex,
   input  logic             flush_ex,
   input  logic             in_valid,
   input  logic [EX_W-1:0]  in_ex,
   input  logic [MEM_W-1:0] in_mem,
   input  logic [WB_W-1:0]  in_wb,
   output logic             ex_valid,
   output logic [EX_W-1:0]  ex_ctrl,
   output logic             mem_valid,
   output logic [MEM_W-1:0] mem_ctrl,
   output logic             wb_valid,
   output logic [WB_W-1:0]  wb_ctrl,
   output logic [CNT_W-1:0] bubble_count
);

   logic             idex_v_q,    idex_v_d;
   logic [EX_W-1:0]  idex_ex_q,   idex_ex_d;
   logic [MEM_W-1:0] idex_mem_q,  idex_mem_d;
   logic [WB_W-1:0]  idex_wb_q,   idex_wb_d;
   logic             exmem_v_q,   exmem_v_d;
   logic [MEM_W-1:0] exmem_mem_q, exmem_mem_d;
   logic [WB_W-1:0]  exmem_wb_q,  exmem_wb_d;
   logic             memwb_v_q,   memwb_v_d;
   logic [WB_W-1:0]  memwb_wb_q,  memwb_wb_d;
   logic [CNT_W-1:0] bub_cnt_q,   bub_cnt_d;

   logic             exmem_bubble;

   assign exmem_bubble = flush_ex | stall_idex;

   // Next-state for all pipeline registers and the bubble counter, in hazard priority order.
   always_comb begin
      idex_v_d    = idex_v_q;
      idex_ex_d   = idex_ex_q;
      idex_mem_d  = idex_mem_q;
      idex_wb_d   = idex_wb_q;
      exmem_v_d   = exmem_v_q;
      exmem_mem_d = exmem_mem_q;
      exmem_wb_d  = exmem_wb_q;
      memwb_v_d   = memwb_v_q;
      memwb_wb_d  = memwb_wb_q;
      bub_cnt_d   = bub_cnt_q;
      if (!hold_all) begin
         // ID/EX: flush beats stall; invalid bundles are stored as zero.
         if (flush_idex) begin
            idex_v_d   = 1'b0;
            idex_ex_d  = '0;
            idex_mem_d = '0;
            idex_wb_d  = '0;
         end else if (!stall_idex) begin
            idex_v_d   = in_valid;
            idex_ex_d  = in_valid ? in_ex  : '0;
            idex_mem_d = in_valid ? in_mem : '0;
            idex_wb_d  = in_valid ? in_wb  : '0;
         end
         // EX/MEM: a stalled or killed EX slot becomes a bubble.
         if (exmem_bubble) begin
            exmem_v_d   = 1'b0;
            exmem_mem_d = '0;
            exmem_wb_d  = '0;
         end else begin
            exmem_v_d   = idex_v_q;
            exmem_mem_d = idex_mem_q;
            exmem_wb_d  = idex_wb_q;
         end
         memwb_v_d  = exmem_v_q;
         memwb_wb_d = exmem_wb_q;
         if (exmem_bubble && (bub_cnt_q != '1)) begin
            bub_cnt_d = bub_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idex_v_q    <= 1'b0;
         idex_ex_q   <= '0;
         idex_mem_q  <= '0;
         idex_wb_q   <= '0;
         exmem_v_q   <= 1'b0;
         exmem_mem_q <= '0;
         exmem_wb_q  <= '0;
         memwb_v_q   <= 1'b0;
         memwb_wb_q  <= '0;
         bub_cnt_q   <= '0;
      end else begin
         idex_v_q    <= idex_v_d;
         idex_ex_q   <= idex_ex_d;
         idex_mem_q  <= idex_mem_d;
         idex_wb_q   <= idex_wb_d;
         exmem_v_q   <= exmem_v_d;
         exmem_mem_q <= exmem_mem_d;
         exmem_wb_q  <= exmem_wb_d;
         memwb_v_q   <= memwb_v_d;
         memwb_wb_q  <= memwb_wb_d;
         bub_cnt_q   <= bub_cnt_d;
      end
   end

   assign ex_valid     = idex_v_q;
   assign ex_ctrl      = idex_ex_q & {EX_W{idex_v_q}};
   assign mem_valid    = exmem_v_q;
   assign mem_ctrl     = exmem_mem_q & {MEM_W{exmem_v_q}};
   assign wb_valid     = memwb_v_q;
   assign wb_ctrl      = memwb_wb_q & {WB_W{memwb_v_q}};
   assign bubble_count = bub_cnt_q;

endmodule

// File: tb/tb_cntrl_pipe_hz.sv
// Self-checking bench for cntrl_pipe_hz: directed scenarios plus randomized
// traffic against a three-slot shift-pipeline reference model. A second
// instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_cntrl_pipe_hz;

   typedef struct packed {
      logic       v;
      logic [5:0] ex;
      logic [3:0] mem;
      logic [1:0] wb;
   } bundle_t;

   logic       clk;
   logic       reset;
   logic       hold_all, stall_idex, flush_idex, flush_ex;
   logic       in_valid;
   logic [5:0] in_ex;
   logic [3:0] in_mem;
   logic [1:0] in_wb;

   logic        ex_valid, mem_valid, wb_valid;
   logic [5:0]  ex_ctrl;
   logic [3:0]  mem_ctrl;
   logic [1:0]  wb_ctrl;
   logic [15:0] bubble_count;

   logic        ex_valid2, mem_valid2, wb_valid2;
   logic [5:0]  ex_ctrl2;
   logic [3:0]  mem_ctrl2;
   logic [1:0]  wb_ctrl2;
   logic [1:0]  bubble_count2;

   int vectors;
   int miscompares;

   // Reference model: slot 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB; m_cnt unbounded.
   bundle_t st [3];
   int      m_cnt;

   cntrl_pipe_hz #(.EX_W(6), .MEM_W(4), .WB_W(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .hold_all(hold_all), .stall_idex(stall_idex),
      .flush_idex(flush_idex), .flush_ex(flush_ex), .in_valid(in_valid),
      .in_ex(in_ex), .in_mem(in_mem), .in_wb(in_wb),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .mem_valid(mem_valid),
      .mem_ctrl(mem_ctrl), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
      .bubble_count(bubble_count)
   );

   cntrl_pipe_hz #(.EX_W(6), .MEM_W(4), .WB_W(2), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .hold_all(hold_all), .stall_idex(stall_idex),
      .flush_idex(flush_idex), .flush_ex(flush_ex), .in_valid(in_valid),
      .in_ex(in_ex), .in_mem(in_mem), .in_wb(in_wb),
      .ex_valid(ex_valid2), .ex_ctrl(ex_ctrl2), .mem_valid(mem_valid2),
      .mem_ctrl(mem_ctrl2), .wb_valid(wb_valid2), .wb_ctrl(wb_ctrl2),
      .bubble_count(bubble_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] exp_cnt16();
      return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
   endfunction

   function automatic logic [1:0] exp_cnt2();
      return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
   endfunction

   function automatic logic [5:0] exp_ex();
      return st[0].v ? st[0].ex : 6'h0;
   endfunction

   function automatic logic [3:0] exp_mem();
      return st[1].v ? st[1].mem : 4'h0;
   endfunction

   function automatic logic [1:0] exp_wb();
      return st[2].v ? st[2].wb : 2'h0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) st[i] = '0;
      m_cnt = 0;
   endtask

   task automatic set_in(input logic v, input logic [5:0] e, input logic [3:0] m, input logic [1:0] w);
      in_valid = v; in_ex = e; in_mem = m; in_wb = w;
   endtask

   task automatic set_haz(input logic h, input logic s, input logic fi, input logic fe);
      hold_all = h; stall_idex = s; flush_idex = fi; flush_ex = fe;
   endtask

   // One clock edge: model advances on the same edge, outputs sampled 1 time unit later.
   task automatic step();
      bundle_t incoming;
      @(posedge clk);
      incoming = in_valid ? {1'b1, in_ex, in_mem, in_wb} : '0;
      if (!hold_all) begin
         if (stall_idex || flush_ex) m_cnt++;
         st[2] = st[1];
         st[1] = (stall_idex || flush_ex) ? bundle_t'('0) : st[0];
         if (flush_idex)       st[0] = '0;
         else if (!stall_idex) st[0] = incoming;
      end
      #1;
   endtask

   // Pulse reset low between edges and clear inputs and model.
   task automatic do_reset();
      set_haz(0, 0, 0, 0);
      set_in(0, 6'h0, 4'h0, 2'h0);
      #2 reset = 1'b0;
      model_clear();
      #2 reset = 1'b1;
   endtask

   task automatic test_reset();
      set_haz(0, 1, 0, 1);
      set_in(1, 6'h3F, 4'hF, 2'h3);
      reset = 1'b0;
      model_clear();
      #1;
      vectors++;
      if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_valids: got %b expected 000", {ex_valid, mem_valid, wb_valid});
      end
      vectors++;
      if ({ex_ctrl, mem_ctrl, wb_ctrl, bubble_count} !== 28'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h expected 0", {ex_ctrl, mem_ctrl, wb_ctrl, bubble_count});
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({ex_valid, ex_ctrl, bubble_count} !== 23'h0) begin
         miscompares++;
         $display("FAIL reset_held_low: got %h expected 0", {ex_valid, ex_ctrl, bubble_count});
      end
      do_reset();
   endtask

   task automatic test_flow();
      do_reset();
      set_in(1, 6'h2A, 4'h5, 2'b01);
      step();
      set_in(0, 6'h00, 4'h0, 2'b00);
      vectors++;
      if ({ex_valid, ex_ctrl} !== {1'b1, 6'h2A}) begin
         miscompares++;
         $display("FAIL flow_ex: got %b/%h expected 1/2a", ex_valid, ex_ctrl);
      end
      step();
      vectors++;
      if ({mem_valid, mem_ctrl, ex_valid} !== {1'b1, 4'h5, 1'b0}) begin
         miscompares++;
         $display("FAIL flow_mem: got %b/%h ex_valid %b expected 1/5 ex_valid 0", mem_valid, mem_ctrl, ex_valid);
      end
      step();
      vectors++;
      if ({wb_valid, wb_ctrl} !== {1'b1, 2'b01}) begin
         miscompares++;
         $display("FAIL flow_wb: got %b/%b expected 1/01", wb_valid, wb_ctrl);
      end
      vectors++;
      if (bubble_count !== 16'd0) begin
         miscompares++;
         $display("FAIL flow_count: got %0d expected 0", bubble_count);
      end
   endtask

   task automatic test_invalid_gating();
      do_reset();
      set_in(0, 6'h3F, 4'hF, 2'b11);
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if ({ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl} !== 15'h0) begin
            miscompares++;
            $display("FAIL gating_cycle%0d: got %h expected 0", i,
                     {ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl});
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      set_in(1, 6'h11, 4'h3, 2'b10);
      step();
      set_in(1, 6'h22, 4'h6, 2'b01);
      set_haz(0, 1, 0, 0);
      vectors++;
      if (ex_ctrl !== 6'h11) begin
         miscompares++;
         $display("FAIL stall_ex_load: got %h expected 11", ex_ctrl);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if ({ex_ctrl, mem_valid} !== {6'h11, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got ex %h mem_valid %b expected ex 11 mem_valid 0", i, ex_ctrl, mem_valid);
         end
      end
      set_haz(0, 0, 0, 0);
      step();
      vectors++;
      if ({ex_ctrl, mem_valid, mem_ctrl} !== {6'h22, 1'b1, 4'h3}) begin
         miscompares++;
         $display("FAIL stall_release: got ex %h mem %b/%h expected ex 22 mem 1/3", ex_ctrl, mem_valid, mem_ctrl);
      end
      vectors++;
      if (bubble_count !== 16'd2) begin
         miscompares++;
         $display("FAIL stall_count: got %0d expected 2", bubble_count);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_in(1, 6'h0C, 4'b0010, 2'b01);
      step();
      set_in(0, 6'h00, 4'h0, 2'b00);
      set_haz(0, 0, 0, 1);
      step();
      set_haz(0, 0, 0, 0);
      vectors++;
      if ({mem_valid, mem_ctrl} !== 5'h0) begin
         miscompares++;
         $display("FAIL flush_ex_mem: got %b/%h expected 0/0", mem_valid, mem_ctrl);
      end
      step();
      vectors++;
      if ({wb_valid, wb_ctrl, bubble_count} !== {1'b0, 2'b00, 16'd1}) begin
         miscompares++;
         $display("FAIL flush_ex_wb: got wb %b/%b count %0d expected 0/00 count 1", wb_valid, wb_ctrl, bubble_count);
      end
      set_in(1, 6'h15, 4'h9, 2'b11);
      step();
      set_haz(0, 1, 1, 0);
      step();
      set_haz(0, 0, 0, 0);
      vectors++;
      if ({ex_valid, ex_ctrl, bubble_count} !== {1'b0, 6'h00, 16'd2}) begin
         miscompares++;
         $display("FAIL flush_beats_stall: got %b/%h count %0d expected 0/00 count 2", ex_valid, ex_ctrl, bubble_count);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         set_in(1, 6'(i), 4'(i), 2'(i));
         step();
      end
      set_haz(1, 1, 0, 0);
      set_in(1, 6'h3F, 4'hF, 2'h3);
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if ({ex_valid, ex_ctrl, mem_valid, mem_ctrl, wb_valid, wb_ctrl, bubble_count} !==
             {1'b1, 6'h03, 1'b1, 4'h2, 1'b1, 2'h1, 16'd0}) begin
            miscompares++;
            $display("FAIL freeze%0d: got ex %h mem %h wb %h count %0d expected ex 03 mem 2 wb 1 count 0",
                     i, ex_ctrl, mem_ctrl, wb_ctrl, bubble_count);
         end
      end
      set_haz(0, 0, 0, 0);
   endtask

   task automatic test_saturation();
      do_reset();
      set_haz(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step();
      set_haz(0, 0, 0, 0);
      vectors++;
      if (bubble_count2 !== 2'd3) begin
         miscompares++;
         $display("FAIL sat_cnt2: got %0d expected 3", bubble_count2);
      end
      vectors++;
      if (bubble_count !== 16'd5) begin
         miscompares++;
         $display("FAIL sat_cnt16: got %0d expected 5", bubble_count);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 6'h30 + 6'(i), 4'h8 + 4'(i), 2'b11);
         step();
      end
      set_haz(0, 1, 0, 1);
      #2 reset = 1'b0;
      model_clear();
      #1;
      vectors++;
      if ({ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl, bubble_count} !== 31'h0) begin
         miscompares++;
         $display("FAIL async_reset: got %h expected 0",
                  {ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl, bubble_count});
      end
      set_haz(0, 0, 0, 0);
      set_in(1, 6'h1B, 4'h4, 2'b10);
      #1 reset = 1'b1;
      step();
      vectors++;
      if ({ex_valid, ex_ctrl, mem_valid, bubble_count} !== {1'b1, 6'h1B, 1'b0, 16'd0}) begin
         miscompares++;
         $display("FAIL async_reset_reload: got ex %b/%h mem_valid %b count %0d expected 1/1b 0 0",
                  ex_valid, ex_ctrl, mem_valid, bubble_count);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         set_haz(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
         set_in(1'($urandom), 6'($urandom), 4'($urandom), 2'($urandom));
         step();
         vectors++;
         if ({ex_valid, ex_ctrl, mem_valid, mem_ctrl, wb_valid, wb_ctrl} !==
             {st[0].v, exp_ex(), st[1].v, exp_mem(), st[2].v, exp_wb()}) begin
            miscompares++;
            $display("FAIL rand%0d_stages: got ex %b/%h mem %b/%h wb %b/%h expected ex %b/%h mem %b/%h wb %b/%h",
                     i, ex_valid, ex_ctrl, mem_valid, mem_ctrl, wb_valid, wb_ctrl,
                     st[0].v, exp_ex(), st[1].v, exp_mem(), st[2].v, exp_wb());
         end
         vectors++;
         if ({ex_ctrl2, mem_ctrl2, wb_ctrl2} !== {exp_ex(), exp_mem(), exp_wb()}) begin
            miscompares++;
            $display("FAIL rand%0d_sat_stages: got %h expected %h", i,
                     {ex_ctrl2, mem_ctrl2, wb_ctrl2}, {exp_ex(), exp_mem(), exp_wb()});
         end
         vectors++;
         if ({bubble_count, bubble_count2} !== {exp_cnt16(), exp_cnt2()}) begin
            miscompares++;
            $display("FAIL rand%0d_count: got %0d/%0d expected %0d/%0d", i,
                     bubble_count, bubble_count2, exp_cnt16(), exp_cnt2());
         end
      end
      set_haz(0, 0, 0, 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      set_haz(0, 0, 0, 0);
      set_in(0, 6'h0, 4'h0, 2'h0);
      model_clear();
      #1;
      test_reset();
      test_flow();
      test_invalid_gating();
      test_stall();
      test_flush();
      test_freeze();
      test_saturation();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
